// File: rtl/mem_responder.sv
// mem_responder: byte-bus target with RAM, UART TX/RX FIFOs, status byte and halt flag (ports: clk/rst, rdy, mem_a/mem_wr/mem_dout/mem_din, io_buffer_full, tx_*, rx_*, halt)
module mem_responder #(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        halt
);
  localparam int TW = $clog2(TX_DEPTH);
  localparam int RW = $clog2(RX_DEPTH);
  logic [7:0] ram [2**RAM_AW];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [TW:0] tx_wp, tx_rp, tx_cnt, tx_nxt;
  logic [RW:0] rx_wp, rx_rp;
  logic [7:0] ram_q, io_q, io_rd;
  logic sel_io_q, acc, io, data_sel, stat_sel;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop;
  logic unused;
  always_comb begin
    acc = rdy && !rst;
    io = mem_a[17:16] == 2'b11;
    data_sel = io && mem_a[2:0] == 3'd0;
    stat_sel = io && mem_a[2:0] == 3'd4;
    tx_empty = tx_wp == tx_rp;
    tx_full = tx_wp == {~tx_rp[TW], tx_rp[TW-1:0]};
    rx_empty = rx_wp == rx_rp;
    rx_full = rx_wp == {~rx_rp[RW], rx_rp[RW-1:0]};
    tx_pop = !tx_empty && tx_ready;
    tx_push = acc && mem_wr && data_sel && (!tx_full || tx_pop);
    tx_cnt = tx_wp - tx_rp;
    tx_nxt = tx_cnt + (TW+1)'(tx_push) - (TW+1)'(tx_pop);
    rx_pop = acc && !mem_wr && data_sel && !rx_empty;
    rx_push = rx_valid && (!rx_full || rx_pop);
    io_rd = data_sel ? (rx_empty ? 8'h00 : rx_mem[rx_rp[RW-1:0]])
          : stat_sel ? {6'b0, tx_full, !rx_empty} : 8'h00;
  end
  assign tx_valid = !tx_empty;
  assign tx_data = tx_mem[tx_rp[TW-1:0]];
  assign mem_din = sel_io_q ? io_q : ram_q;
  assign unused = ^mem_a[31:18];
  // RAM array and its read register carry no reset so they map onto block RAM
  always_ff @(posedge clk) begin
    if (acc && mem_wr && !io) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
    if (acc && !mem_wr && !io) ram_q <= ram[mem_a[RAM_AW-1:0]];
    if (tx_push) tx_mem[tx_wp[TW-1:0]] <= mem_dout;
    if (rx_push) rx_mem[rx_wp[RW-1:0]] <= rx_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      io_q <= 8'h00;
      sel_io_q <= 1'b1;
      io_buffer_full <= 1'b0;
      halt <= 1'b0;
    end else begin
      tx_wp <= tx_wp + (TW+1)'(tx_push);
      tx_rp <= tx_rp + (TW+1)'(tx_pop);
      rx_wp <= rx_wp + (RW+1)'(rx_push);
      rx_rp <= rx_rp + (RW+1)'(rx_pop);
      // two-entry margin absorbs the controller's stall-check latency
      io_buffer_full <= tx_nxt >= (TW+1)'(TX_DEPTH - 2);
      if (acc && !mem_wr) sel_io_q <= io;
      if (acc && !mem_wr && io) io_q <= io_rd;
      if (acc && mem_wr && stat_sel) halt <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table plus TX/RX/reset sequences for mem_responder
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst, rdy, mem_wr, tx_ready, rx_valid, io_buffer_full, tx_valid, halt;
  logic [31:0] mem_a;
  logic [7:0] mem_dout, mem_din, tx_data, rx_data;
  int n_cmp = 0;
  int n_bad = 0;

  mem_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r; logic [31:0] a; logic w; logic [7:0] d; logic rv; logic [7:0] rd;
    logic [7:0] din; logic txv; logic hlt;
  } vec_t;
  vec_t v[26];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d,
                       input logic tr, input logic rv, input logic [7:0] rd);
    rdy = r; mem_a = a; mem_wr = w; mem_dout = d; tx_ready = tr; rx_valid = rv; rx_data = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic tr);
    drive(1'b1, 32'h30002, 1'b0, 8'h00, tr, 1'b0, 8'h00);
  endtask

  initial begin
    v = '{
      '{1, 32'h00010, 1, 8'hA5, 0, 8'h00, 8'h00, 0, 0},
      '{1, 32'h00010, 0, 8'h00, 0, 8'h00, 8'hA5, 0, 0},
      '{1, 32'h30002, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0},
      '{1, 32'h20010, 0, 8'h00, 0, 8'h00, 8'hA5, 0, 0},
      '{1, 32'h00005, 1, 8'h3C, 0, 8'h00, 8'hA5, 0, 0},
      '{0, 32'h30004, 1, 8'h00, 0, 8'h00, 8'hA5, 0, 0},
      '{0, 32'h00005, 1, 8'hFF, 0, 8'h00, 8'hA5, 0, 0},
      '{0, 32'h30002, 0, 8'h00, 0, 8'h00, 8'hA5, 0, 0},
      '{1, 32'h00005, 0, 8'h00, 0, 8'h00, 8'h3C, 0, 0},
      '{1, 32'h30002, 0, 8'h00, 1, 8'h37, 8'h00, 0, 0},
      '{1, 32'h30004, 0, 8'h00, 1, 8'h38, 8'h01, 0, 0},
      '{1, 32'h30001, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0},
      '{1, 32'h30004, 0, 8'h00, 0, 8'h00, 8'h01, 0, 0},
      '{1, 32'h30000, 0, 8'h00, 0, 8'h00, 8'h37, 0, 0},
      '{1, 32'h30000, 0, 8'h00, 0, 8'h00, 8'h38, 0, 0},
      '{1, 32'h30000, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0},
      '{1, 32'h30004, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0},
      '{1, 32'h30000, 0, 8'h00, 1, 8'h55, 8'h00, 0, 0},
      '{1, 32'h30000, 0, 8'h00, 0, 8'h00, 8'h55, 0, 0},
      '{0, 32'h30000, 0, 8'h00, 1, 8'h66, 8'h55, 0, 0},
      '{1, 32'h30000, 0, 8'h00, 0, 8'h00, 8'h66, 0, 0},
      '{1, 32'h30004, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0},
      '{1, 32'h30003, 1, 8'h77, 0, 8'h00, 8'h00, 0, 0},
      '{0, 32'h30000, 1, 8'h12, 0, 8'h00, 8'h00, 0, 0},
      '{1, 32'h30004, 1, 8'h00, 0, 8'h00, 8'h00, 0, 1},
      '{1, 32'h30002, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1}
    };
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk("reset din", mem_din, 8'h00);
    chk("reset iof", {7'b0, io_buffer_full}, 8'h00);
    chk("reset txv", {7'b0, tx_valid}, 8'h00);
    chk("reset halt", {7'b0, halt}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 26; i++) begin
      drive(v[i].r, v[i].a, v[i].w, v[i].d, 1'b0, v[i].rv, v[i].rd);
      chk($sformatf("v%0d din", i), mem_din, v[i].din);
      chk($sformatf("v%0d txv", i), {7'b0, tx_valid}, {7'b0, v[i].txv});
      chk($sformatf("v%0d halt", i), {7'b0, halt}, {7'b0, v[i].hlt});
      chk($sformatf("v%0d iof", i), {7'b0, io_buffer_full}, 8'h00);
    end
    // TX burst with the transmitter stalled
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h30000, 1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 8'h00);
      chk($sformatf("burst%0d iof", i), {7'b0, io_buffer_full}, {7'b0, i + 1 >= 14});
      chk($sformatf("burst%0d txv", i), {7'b0, tx_valid}, 8'h01);
      chk($sformatf("burst%0d txd", i), tx_data, 8'h41);
    end
    drive(1'b1, 32'h30000, 1'b1, 8'h51, 1'b0, 1'b0, 8'h00);
    chk("overflow iof", {7'b0, io_buffer_full}, 8'h01);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d txv", k), {7'b0, tx_valid}, 8'h01);
      chk($sformatf("drain%0d txd", k), tx_data, 8'h41 + 8'(k));
      idle(1'b1);
      chk($sformatf("drain%0d iof", k), {7'b0, io_buffer_full}, {7'b0, 15 - k >= 14});
    end
    chk("drain empty txv", {7'b0, tx_valid}, 8'h00);
    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) drive(1'b1, 32'h30000, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 8'h00);
    drive(1'b1, 32'h30000, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00);
    chk("fullpp iof", {7'b0, io_buffer_full}, 8'h01);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fullpp%0d txd", k), tx_data, k < 15 ? 8'h61 + 8'(k) : 8'h99);
      idle(1'b1);
    end
    chk("fullpp empty txv", {7'b0, tx_valid}, 8'h00);
    // reset while both FIFOs hold data
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h30000, 1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h30002, 1'b0, 8'h00, 1'b0, 1'b1, 8'h80 + 8'(i));
    drive(1'b1, 32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("pre-rst status", mem_din, 8'h01);
    chk("pre-rst halt", {7'b0, halt}, 8'h01);
    chk("pre-rst txv", {7'b0, tx_valid}, 8'h01);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    chk("rst txv", {7'b0, tx_valid}, 8'h00);
    chk("rst iof", {7'b0, io_buffer_full}, 8'h00);
    chk("rst halt", {7'b0, halt}, 8'h00);
    drive(1'b1, 32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("rst status", mem_din, 8'h00);
    drive(1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("rst rx data", mem_din, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
